// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Holds the default counter width and divisor, the stopwatch rate divisors
// for a 100 MHz system clock, the channel-index type and a helper that sizes
// the channel-select port.
package tick_gen_pkg;

  // Default counter/divisor width and post-reset divisor.
  localparam int unsigned TG_CNT_W_DEF       = 32'd27;
  localparam int unsigned TG_DEFAULT_DIV_DEF = 32'd100000000;

  // Stopwatch rate divisors (100 MHz clock).
  localparam int unsigned TG_DIV_1HZ  = 32'd100000000;
  localparam int unsigned TG_DIV_2HZ  = 32'd50000000;
  localparam int unsigned TG_DIV_SCAN = 32'd262144;
  localparam int unsigned TG_DIV_5HZ  = 32'd20000000;

  // Upper bound on the channel count; the index type covers it.
  localparam int unsigned TG_MAX_CH = 32'd16;

  typedef logic [3:0] tg_ch_idx_t;

  // Width of the channel-select port: at least one bit even for one channel.
  function automatic int unsigned tg_idx_w(input int unsigned num_ch);
    if (num_ch > 32'd1) begin
      return int'($clog2(num_ch));
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick-generator channel: counter, active and pending divisor, the
// registered tick and (with TICK_GEN_SQUARE_EN defined) a registered square
// wave that is high for the first floor(div/2) counts of each period.
// A pending divisor only takes effect at a wrap, while the channel is
// disabled, or on a phase-align clear, so a period is never cut short.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = TG_CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = TG_DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_wr_hit,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_cnt
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic             o_sq
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pv;
  logic             r_tick;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_pv_nxt;
  logic             w_tick_nxt;
  logic             w_term;

  // Next-state decode: clear > disabled load > terminal wrap > increment.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_div_nxt  = r_div;
    w_pend_nxt = r_pend;
    w_pv_nxt   = r_pv;
    w_tick_nxt = 1'b0;
    w_term     = (r_cnt == (r_div - CNT_ONE));

    if (i_sync_clr) begin
      // Phase align: a same-cycle write wins over an older pending value.
      w_cnt_nxt = CNT_ZERO;
      w_pv_nxt  = 1'b0;
      if (i_wr_hit) begin
        w_div_nxt = i_wr_div;
      end else if (r_pv) begin
        w_div_nxt = r_pend;
      end else begin
        w_div_nxt = r_div;
      end
    end else if (!i_en) begin
      // Idle channel: apply a pending divisor right away and restart.
      if (r_pv) begin
        w_div_nxt = r_pend;
        w_cnt_nxt = CNT_ZERO;
        w_pv_nxt  = 1'b0;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (w_term) begin
      w_cnt_nxt  = CNT_ZERO;
      w_tick_nxt = 1'b1;
      if (r_pv) begin
        w_div_nxt = r_pend;
        w_pv_nxt  = 1'b0;
      end else begin
        w_div_nxt = r_div;
      end
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end

    // A write captured now waits for the next application point, so a
    // write on the terminal cycle is not applied at that wrap.
    if (i_wr_hit && !i_sync_clr) begin
      w_pend_nxt = i_wr_div;
      w_pv_nxt   = 1'b1;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= CNT_ZERO;
      r_div  <= DIV_RST;
      r_pend <= DIV_RST;
      r_pv   <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_div  <= w_div_nxt;
      r_pend <= w_pend_nxt;
      r_pv   <= w_pv_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign o_tick = r_tick;
  assign o_cnt  = r_cnt;

`ifdef TICK_GEN_SQUARE_EN
  logic r_sq;
  logic w_sq_nxt;

  // Square level follows the next counter against half the next divisor;
  // div == 1 gives a half of 0, so the wave stays low.
  always_comb begin
    w_sq_nxt = (w_cnt_nxt < (w_div_nxt >> 1));
  end

  // Square-wave register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sq <= 1'b0;
    end else begin
      r_sq <= w_sq_nxt;
    end
  end

  assign o_sq = r_sq;
`else
  // Square-wave output not built.
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator top level. Decodes divisor writes, reports
// rejected writes on wr_err one cycle later, and instantiates one
// tick_gen_ch per channel. Defining TICK_GEN_SQUARE_EN adds the sq output.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 32'd4,
  parameter int unsigned CNT_W       = TG_CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = TG_DEFAULT_DIV_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           en,
  input  logic                        sync_clr,
  input  logic                        wr_en,
  input  logic [tg_idx_w(NUM_CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]            wr_div,
  output logic                        wr_err,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH*CNT_W-1:0]     cnt
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [NUM_CH-1:0]           sq
`endif
);

  logic [4:0]        w_num_ch;
  tg_ch_idx_t        w_wr_idx;
  logic              w_ch_ok;
  logic              w_div_ok;
  logic              w_wr_ok;
  logic              w_wr_bad;
  logic [NUM_CH-1:0] w_wr_hit;
  logic              r_wr_err;

  // Write qualification: channel in range and a non-zero divisor.
  always_comb begin
    w_num_ch = 5'(NUM_CH);
    w_wr_idx = tg_ch_idx_t'(wr_ch);
    w_ch_ok  = ({1'b0, w_wr_idx} < w_num_ch);
    w_div_ok = (wr_div != {CNT_W{1'b0}});
    w_wr_ok  = wr_en & w_ch_ok & w_div_ok;
    w_wr_bad = wr_en & ~(w_ch_ok & w_div_ok);
  end

  // Rejected-write pulse, one cycle after the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_bad;
    end
  end

  assign wr_err = r_wr_err;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_wr_hit[gi] = w_wr_ok & (w_wr_idx == tg_ch_idx_t'(gi));

    tick_gen_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_en       (en[gi]),
      .i_sync_clr (sync_clr),
      .i_wr_hit   (w_wr_hit[gi]),
      .i_wr_div   (wr_div),
      .o_tick     (tick[gi]),
      .o_cnt      (cnt[gi*CNT_W +: CNT_W])
`ifdef TICK_GEN_SQUARE_EN
      ,
      .o_sq       (sq[gi])
`endif
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: an elapsed-cycle model checked every
// cycle, plus directed sequences with hand-computed tick edges.
module tb_tick_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEF    = 4;
  localparam int CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic                    sync_clr;
  logic                    wr_en;
  logic [CH_W-1:0]         wr_ch;
  logic [CNT_W-1:0]        wr_div;
  logic                    wr_err;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*CNT_W-1:0] cnt;
`ifdef TICK_GEN_SQUARE_EN
  logic [NUM_CH-1:0]       sq;
`endif

  tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .wr_err(wr_err), .tick(tick), .cnt(cnt)
`ifdef TICK_GEN_SQUARE_EN
    , .sq(sq)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int cnt_of(input int ch);
    return int'(cnt[ch*CNT_W +: CNT_W]);
  endfunction

  // Model: elapsed enabled cycles in the current period, active divisor,
  // pending divisor (0 = none).
  int m_el[NUM_CH];
  int m_div[NUM_CH];
  int m_pend[NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic m_err;

  always @(posedge clk or negedge rst) begin : model
    int el[NUM_CH];
    int dv[NUM_CH];
    int pd[NUM_CH];
    logic [NUM_CH-1:0] tk;
    bit ok;
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_el[c] <= 0; m_div[c] <= DEF; m_pend[c] <= 0;
      end
      m_tick <= '0;
      m_err  <= 1'b0;
    end else begin
      ok = wr_en && (int'(wr_ch) < NUM_CH) && (wr_div != 0);
      for (int c = 0; c < NUM_CH; c++) begin
        el[c] = m_el[c]; dv[c] = m_div[c]; pd[c] = m_pend[c]; tk[c] = 1'b0;
        if (sync_clr) begin
          el[c] = 0;
          if (ok && int'(wr_ch) == c) dv[c] = int'(wr_div);
          else if (pd[c] != 0) dv[c] = pd[c];
          pd[c] = 0;
        end else if (!en[c]) begin
          if (pd[c] != 0) begin dv[c] = pd[c]; pd[c] = 0; el[c] = 0; end
        end else begin
          el[c] = el[c] + 1;
          if (el[c] == dv[c]) begin
            tk[c] = 1'b1; el[c] = 0;
            if (pd[c] != 0) begin dv[c] = pd[c]; pd[c] = 0; end
          end
        end
        if (!sync_clr && ok && int'(wr_ch) == c) pd[c] = int'(wr_div);
      end
      m_el <= el; m_div <= dv; m_pend <= pd; m_tick <= tk;
      m_err <= wr_en && !ok;
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("model_cnt%0d", c), cnt_of(c), m_el[c]);
        check($sformatf("model_tick%0d", c), int'(tick[c]), int'(m_tick[c]));
      end
      check("model_wr_err", int'(wr_err), int'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    sync_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_wr(input int ch, input int dv);
    wr_en = 1'b1;
    wr_ch = CH_W'(ch);
    wr_div = CNT_W'(dv);
  endtask

  task automatic expect_ticks(input int ch, input int first, input int last,
                              input logic [31:0] mask, input string nm);
    for (int e = first; e <= last; e++) begin
      step();
      check($sformatf("%s_e%0d", nm, e), int'(tick[ch]), int'(mask[e]));
    end
  endtask

  int lit_cnt[12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int rnd;

  initial begin
    rst = 1'b0; en = '0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (2) @(negedge clk);
    check("rst_cnt", int'(cnt), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_wr_err", int'(wr_err), 0);
    chk_on = 1'b1;
    rst = 1'b1;
    en = 3'b111;

    // T1: default divisor 4 -> ticks at edges 4, 8, 12.
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("t1_cnt_e%0d", e), cnt_of(0), lit_cnt[e-1]);
      check($sformatf("t1_tick_e%0d", e), int'(tick[0]), (e == 4 || e == 8 || e == 12) ? 1 : 0);
    end

    // T2: div 5, write 2 at cnt 1 -> ticks at 5, 7, 9.
    drive_wr(1, 5); sync_clr = 1'b1;
    step();
    check("t2_clr_cnt", cnt_of(1), 0);
    check("t2_clr_tick", int'(tick), 0);
    step();
    check("t2_cnt1", cnt_of(1), 1);
    drive_wr(1, 2);
    expect_ticks(1, 2, 9, 32'h0000_02A0, "t2_tick");

    // T3: write 3 on the terminal cycle of a div-4 period -> 4, 8, 11, 14.
    sync_clr = 1'b1;
    step();
    repeat (3) step();
    check("t3_cnt3", cnt_of(2), 3);
    drive_wr(2, 3);
    expect_ticks(2, 4, 14, 32'h0000_4910, "t3_tick");

    // T4: rejected writes.
    drive_wr(0, 0);
    step();
    check("t4_err_div0", int'(wr_err), 1);
    drive_wr(3, 9);
    step();
    check("t4_err_ch", int'(wr_err), 1);
    step();
    check("t4_err_clear", int'(wr_err), 0);
    sync_clr = 1'b1;
    step();
    expect_ticks(0, 1, 4, 32'h0000_0010, "t4_ch0_div4");

    // T5: div 3 and 7, sync_clr at an arbitrary point.
    drive_wr(0, 3); sync_clr = 1'b1;
    step();
    drive_wr(1, 7); sync_clr = 1'b1;
    step();
    rnd = $urandom_range(2, 9);
    repeat (rnd) step();
    sync_clr = 1'b1;
    step();
    check("t5_cnt0", cnt_of(0), 0);
    check("t5_cnt1", cnt_of(1), 0);
    check("t5_tick", int'(tick), 0);
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("t5_tick0_e%0d", e), int'(tick[0]), (e % 3 == 0) ? 1 : 0);
      check($sformatf("t5_tick1_e%0d", e), int'(tick[1]), (e == 7) ? 1 : 0);
    end

    // T6: disable at cnt 2, write 6 while idle, re-enable.
    sync_clr = 1'b1;
    step();
    step();
    step();
    check("t6_cnt2", cnt_of(2), 2);
    en = 3'b011;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t6_hold_cnt_%0d", k), cnt_of(2), 2);
      check($sformatf("t6_hold_tick_%0d", k), int'(tick[2]), 0);
    end
    drive_wr(2, 6);
    step();
    check("t6_cnt_pending", cnt_of(2), 2);
    check("t6_no_err", int'(wr_err), 0);
    step();
    check("t6_cnt_loaded", cnt_of(2), 0);
    en = 3'b111;
    expect_ticks(2, 1, 12, 32'h0000_1040, "t6_tick");

    // T7: reset mid-period discards a pending write.
    sync_clr = 1'b1;
    step();
    step();
    drive_wr(0, 5);
    step();
    check("t7_cnt_pre", cnt_of(0), 2);
    #2 rst = 1'b0;
    #1;
    check("t7_async_cnt", int'(cnt), 0);
    check("t7_async_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b1;
    expect_ticks(0, 1, 8, 32'h0000_0110, "t7_tick");

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
